// File: rtl/top_addsub.sv
// top_addsub: registered 4-bit two's-complement adder/subtractor with
// carry, zero and overflow flags. One operation per clock, no backpressure.
// Optional build macro TOP_ADDSUB_INREG_EN adds an input register stage,
// raising latency from 1 to 2 cycles without changing any result or flag.
module top_addsub (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       sub_add,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] result,
    output logic       carry,
    output logic       zero,
    output logic       overflow,
    output logic       out_valid
);

    // Operands as seen by the arithmetic stage
    logic       op_valid;
    logic       op_sub;
    logic [3:0] op_a;
    logic [3:0] op_b;

`ifdef TOP_ADDSUB_INREG_EN
    logic       in_valid_q, in_valid_d;
    logic       sub_add_q,  sub_add_d;
    logic [3:0] a_q,        a_d;
    logic [3:0] b_q,        b_d;

    // Input stage: capture operands every cycle; in_valid travels alongside
    always_comb begin
        in_valid_d = in_valid;
        sub_add_d  = sub_add;
        a_d        = a;
        b_d        = b;
    end

    // Input stage register, cleared by reset like the output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            sub_add_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            in_valid_q <= in_valid_d;
            sub_add_q  <= sub_add_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    assign op_valid = in_valid_q;
    assign op_sub   = sub_add_q;
    assign op_a     = a_q;
    assign op_b     = b_q;
`else
    assign op_valid = in_valid;
    assign op_sub   = sub_add;
    assign op_a     = a;
    assign op_b     = b;
`endif

    logic [3:0] nb;
    logic [4:0] sum;
    logic       ovf;

    // Arithmetic: subtract adds the 4-bit two's complement of b, so b=0
    // yields nb=0 and carry=0 (no carry-in trick that would set it)
    always_comb begin
        nb  = op_sub ? (~op_b + 4'd1) : op_b;
        sum = {1'b0, op_a} + {1'b0, nb};
        if (op_sub)
            ovf = (op_a[3] != op_b[3]) && (sum[3] != op_a[3]);
        else
            ovf = (op_a[3] == op_b[3]) && (sum[3] != op_a[3]);
    end

    logic [3:0] result_q, result_d;
    logic       carry_q,  carry_d;
    logic       zero_q,   zero_d;
    logic       ovf_q,    ovf_d;
    logic       out_valid_q, out_valid_d;

    // Output next-state: load on an accepted operation, otherwise hold
    always_comb begin
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = op_valid;
        if (op_valid) begin
            result_d = sum[3:0];
            carry_d  = sum[4];
            zero_d   = ~|sum[3:0];
            ovf_d    = ovf;
        end
    end

    // Output register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_top_addsub.sv
// Testbench for top_addsub: directed vector table, reset-in-flight
// sequence and exhaustive back-to-back sweep against an equation model.
module tb_top_addsub;

`ifdef TOP_ADDSUB_INREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       sub_add;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       overflow;
    logic       out_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    top_addsub dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .sub_add  (sub_add),
        .a        (a),
        .b        (b),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .overflow (overflow),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sa;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       c;
        logic       z;
        logic       v;
    } vec_t;

    vec_t vecs [11];

    // Packed observation: {result, carry, zero, overflow, out_valid}
    function automatic logic [7:0] obs();
        return {result, carry, zero, overflow, out_valid};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got r=%h c=%b z=%b v=%b ov=%b, want r=%h c=%b z=%b v=%b ov=%b",
                     name, got[7:4], got[3], got[2], got[1], got[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Reference model written straight from the operation equations
    function automatic logic [6:0] model(input logic sa, input logic [3:0] x, input logic [3:0] y);
        logic [3:0] nb;
        logic [4:0] s;
        logic       v;
        nb = sa ? 4'((16 - int'(y)) % 16) : y;
        s  = 5'(int'(x) + int'(nb));
        if (sa) v = (x[3] != y[3]) && (s[3] != x[3]);
        else    v = (x[3] == y[3]) && (s[3] != x[3]);
        return {s[3:0], s[4], (s[3:0] == 4'h0), v};
    endfunction

    // Issue one operation, wait out the latency, check, then check the hold cycle
    task automatic run_vec(input vec_t t, input int idx);
        logic [7:0] exp;
        sub_add  = t.sa;
        a        = t.a;
        b        = t.b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 4'h0;
        b        = 4'h0;
        for (int unsigned k = 1; k < LAT; k++) begin
            @(posedge clk); #1;
        end
        exp = {t.r, t.c, t.z, t.v, 1'b1};
        check($sformatf("vec%0d", idx), obs(), exp);
        @(posedge clk); #1;
        exp[0] = 1'b0;
        check($sformatf("vec%0d_hold", idx), obs(), exp);
    endtask

    initial begin
        vec_t t;
        logic [6:0] m;
        logic [7:0] exp;

        //          sa    a      b      r      c     z     v
        vecs[0]  = '{1'b0, 4'h3, 4'h2, 4'h5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'h2, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'h3, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 4'h0, 4'h8, 4'h8, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        sub_add  = 1'b0;
        a        = 4'h0;
        b        = 4'h0;
        #1;
        check("reset_state", obs(), 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", obs(), 8'h00);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Leave a nonzero result held, then reset with a new op in flight
        t = vecs[0];
        run_vec(t, 99);
        sub_add  = 1'b0;
        a        = 4'h7;
        b        = 4'h1;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", obs(), 8'h00);
        @(posedge clk); #1;
        check("rst_wins_over_valid", obs(), 8'h00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        for (int unsigned k = 0; k < LAT + 1; k++) begin
            @(posedge clk); #1;
            check($sformatf("no_inflight_%0d", k), obs(), 8'h00);
        end

        // Exhaustive sweep, one new operation every cycle
        for (int k = 0; k < 512 + int'(LAT) - 1; k++) begin
            int idx;
            if (k < 512) begin
                sub_add  = k[8];
                a        = k[7:4];
                b        = k[3:0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            idx = k - (int'(LAT) - 1);
            if (idx >= 0) begin
                m   = model(idx[8], idx[7:4], idx[3:0]);
                exp = {m, 1'b1};
                check($sformatf("sweep_%s_a%0d_b%0d", idx[8] ? "sub" : "add", idx[7:4], idx[3:0]),
                      obs(), exp);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        m   = model(1'b1, 4'hF, 4'hF);
        exp = {m, 1'b0};
        check("sweep_tail_hold", obs(), exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/top_addsub.md
# top_addsub

Registered 4-bit two's-complement adder/subtractor with carry, zero and overflow flags. It is the arithmetic core of the small ALU datapath. It takes two 4-bit operands plus an add/subtract select and presents the result and flags from an output register one cycle after the operands are accepted. Flags follow the datapath's flag conventions so that the downstream branch and compare logic can consume them directly.

## Interface
Parameters: none; the datapath width is fixed at 4 bits.

Ports:
- `clk` — input, 1 bit. Single clock; all state updates on the rising edge.
- `rst` — input, 1 bit. Asynchronous, active-high reset.
- `in_valid` — input, 1 bit. The operands and `sub_add` are accepted on a rising `clk` edge while high.
- `sub_add` — input, 1 bit. 0 selects add (a+b); 1 selects subtract (a−b).
- `a` — input, 4 bits. First operand.
- `b` — input, 4 bits. Second operand.
- `result` — output, 4 bits. Low 4 bits of the operation.
- `carry` — output, 1 bit. Carry-out of the 4-bit addition.
- `zero` — output, 1 bit. High when `result` == 4'h0.
- `overflow` — output, 1 bit. Signed (two's-complement) overflow.
- `out_valid` — output, 1 bit. High for one cycle per accepted operation.

## Operation
- Add (`sub_add`=0):
  - {carry,result} = a + b, computed as a 5-bit sum.
  - overflow = (a[3]==b[3]) && (result[3]!=a[3]).
- Subtract (`sub_add`=1):
  - nb = (~b + 1) mod 16, truncated to 4 bits.
  - {carry,result} = a + nb, computed as a 5-bit sum.
  - carry=1 means no borrow, for b≠0.
  - For b=0, nb=0, so carry=0 and result=a. This is required behaviour.
  - overflow = (a[3]!=b[3]) && (result[3]!=a[3]).
- zero = ~|result, evaluated on the 4-bit result only.
- Operands are treated as unsigned for carry and as signed (−8..7) for overflow.
- All four outputs are purely combinational functions of the captured operands. There is no accumulated state between operations.
- While `in_valid`=0:
  - result, carry, zero and overflow hold their last values.
  - out_valid=0.

## Timing
- Latency is 1 cycle. Operands captured at edge N appear on result and the flags after edge N, with out_valid=1 for that one cycle.
- Back-to-back: a new operation may be accepted every cycle, so throughput is 1 per clock. There is no backpressure.
- Reset values: result=4'h0, carry=0, zero=0, overflow=0, out_valid=0.
- Reset is asynchronous, so outputs clear immediately on `rst` assertion.
- An operation in flight when `rst` asserts is discarded.
- The first operation accepted after `rst` deasserts behaves normally.
- Simultaneous `rst` and `in_valid`: reset wins and no operation is accepted.

## Configuration
- `TOP_ADDSUB_INREG_EN` defined:
  - Adds an input register stage: a, b, sub_add and in_valid are registered, then computed and registered again.
  - Latency becomes 2 cycles and throughput stays 1 per clock.
  - The input stage also resets to 0.
- `TOP_ADDSUB_INREG_EN` not defined: single output register stage with latency 1, as described above.
- Results and flags are identical in both builds; only latency differs.

## Test plan
- Add a=3, b=2 → result=5, carry=0, zero=0, overflow=0, out_valid=1 one cycle later.
- Subtract a=2, b=3 → result=4'hF, carry=0, zero=0, overflow=0.
- Subtract a=3, b=3 → result=0, carry=1, zero=1, overflow=0.
- Subtract a=3, b=0 → result=3, carry=0 (b=0 rule), zero=0, overflow=0.
- Add boundary cases:
  - a=7, b=1 → result=4'h8, overflow=1, carry=0.
  - a=4'hF, b=1 → result=0, carry=1, zero=1, overflow=0.
- Assert `rst` while an operation is in flight:
  - All outputs go to 0 asynchronously and the in-flight result never appears.
  - After deassertion, exhaustive a,b ∈ 0..15 × both modes match the equations above, one result per cycle.
